spi_transaction_master: RTL

SPI_TRANSACTION_MASTER -- requirements
Module: spi_transaction_master

---
 rtl/spi_transaction_master_if.sv | 34 +++
 rtl/spi_transaction_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_master_if.sv
// Request, status and serial-pin bundle of the SPI transaction master.
// The master modport is the design side; the slave modport is the requester/pad side.
interface spi_transaction_master_if #(
    parameter int NumSlaves  = 3,
    parameter int MaxTxWidth = 40,
    parameter int RxWidth    = 16
);
    localparam int SelW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int LenW = $clog2(MaxTxWidth + 1);

    logic                  i_start;
    logic                  i_abort;
    logic [SelW-1:0]       i_slave_sel;
    logic [MaxTxWidth-1:0] i_tx_data;
    logic [LenW-1:0]       i_tx_length;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [RxWidth-1:0]    o_rx_data;
    logic                  o_sclk;
    logic [NumSlaves-1:0]  o_nss;
    logic                  o_mosi;
    logic                  i_miso;

    modport master (
        input  i_start, i_abort, i_slave_sel, i_tx_data, i_tx_length, i_miso,
        output o_busy, o_done, o_error, o_rx_data, o_sclk, o_nss, o_mosi
    );

    modport slave (
        output i_start, i_abort, i_slave_sel, i_tx_data, i_tx_length, i_miso,
        input  o_busy, o_done, o_error, o_rx_data, o_sclk, o_nss, o_mosi
    );
endinterface

// File: rtl/spi_transaction_master.sv
// SPI transaction master: handshake, LSB-first transmit, handshake, fixed-width receive.
// Pin/status outputs are registered from the state, so they trail the state by one cycle.
module spi_transaction_master #(
    parameter int NumSlaves     = 3,
    parameter int MaxTxWidth    = 40,
    parameter int RxWidth       = 16,
    parameter int TimeoutCycles = 64
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    spi_transaction_master_if.master        bus
);
    localparam int SelW   = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int LenW   = $clog2(MaxTxWidth + 1);
    localparam int CntMax = (MaxTxWidth > RxWidth) ? MaxTxWidth : RxWidth;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int WaitW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [6:0] {
        IDLE      = 7'b0000001,
        SEND      = 7'b0000010,
        SENDING   = 7'b0000100,
        RECEIVE   = 7'b0001000,
        RECEIVING = 7'b0010000,
        DONE      = 7'b0100000,
        ERROR     = 7'b1000000
    } state_e;

    state_e                state_q, state_d;
    logic [MaxTxWidth-1:0] tx_sh_q, tx_sh_d;
    logic [LenW-1:0]       len_q, len_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic [RxWidth-1:0]    rx_sh_q, rx_sh_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [RxWidth-1:0]    rx_data_q, rx_data_d;
    logic [NumSlaves-1:0]  nss_q, nss_d;
    logic                  mosi_q, mosi_d;

    logic req_bad;
    logic send_last;
    logic recv_last;
    logic timed_out;
    logic active;

    assign req_bad   = (bus.i_tx_length == '0)
                    || (int'(bus.i_tx_length) > MaxTxWidth)
                    || (int'(bus.i_slave_sel) >= NumSlaves);
    assign send_last = (bit_cnt_q == (CntW'(len_q) - CntW'(1)));
    assign recv_last = (bit_cnt_q == CntW'(RxWidth - 1));
    assign timed_out = (TimeoutCycles > 0) && (wait_cnt_q == WaitW'(TimeoutCycles - 1));
    assign active    = (state_q == SEND) || (state_q == SENDING)
                    || (state_q == RECEIVE) || (state_q == RECEIVING);

    always_comb begin
        state_d = state_q;
        tx_sh_d = tx_sh_q;
        len_d   = len_q;
        sel_d   = sel_q;
        rx_sh_d = rx_sh_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    tx_sh_d = bus.i_tx_data;
                    len_d   = bus.i_tx_length;
                    sel_d   = bus.i_slave_sel;
                    state_d = req_bad ? ERROR : SEND;
                end
            end
            SEND: begin
                // A completed handshake wins over a timeout landing on the same cycle.
                if (!bus.i_miso)    state_d = SENDING;
                else if (timed_out) state_d = ERROR;
            end
            SENDING: begin
                tx_sh_d = tx_sh_q >> 1;
                if (send_last) state_d = RECEIVE;
            end
            RECEIVE: begin
                if (bus.i_miso)     state_d = RECEIVING;
                else if (timed_out) state_d = ERROR;
            end
            RECEIVING: begin
                rx_sh_d = {bus.i_miso, rx_sh_q[RxWidth-1:1]};
                if (recv_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.i_abort && (state_q != IDLE)) state_d = IDLE;
    end

    // Both counters restart on every state change, so each state sees a fresh count.
    always_comb begin
        bit_cnt_d  = '0;
        wait_cnt_d = '0;
        if (state_d == state_q) begin
            if ((state_q == SENDING) || (state_q == RECEIVING)) bit_cnt_d  = bit_cnt_q + CntW'(1);
            if ((state_q == SEND) || (state_q == RECEIVE))      wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    always_comb begin
        busy_d    = (state_q != IDLE);
        done_d    = (state_q == DONE) || (state_q == ERROR);
        error_d   = (state_q == ERROR);
        rx_data_d = (state_q == DONE) ? rx_sh_q : rx_data_q;
        mosi_d    = 1'b0;
        if (state_q == SEND)    mosi_d = 1'b1;
        if (state_q == SENDING) mosi_d = tx_sh_q[0];
        nss_d     = '1;
        for (int i = 0; i < NumSlaves; i++) begin
            nss_d[i] = !(active && (int'(sel_q) == i));
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            tx_sh_q    <= '0;
            len_q      <= '0;
            sel_q      <= '0;
            rx_sh_q    <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rx_data_q  <= '0;
            nss_q      <= '1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            len_q      <= len_d;
            sel_q      <= sel_d;
            rx_sh_q    <= rx_sh_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rx_data_q  <= rx_data_d;
            nss_q      <= nss_d;
            mosi_q     <= mosi_d;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_error   = error_q;
    assign bus.o_rx_data = rx_data_q;
    assign bus.o_nss     = nss_q;
    assign bus.o_mosi    = mosi_q;
    assign bus.o_sclk    = i_clock;
endmodule
